// File: rtl/nonogram_pkg.sv
// Shared types and board limits for the nonogram puzzle datapath.
package nonogram_pkg;

   localparam int MAX_ROWS        = 11;
   localparam int MAX_COLS        = 11;
   localparam int LINE_W          = 16;
   localparam int MAX_NUM_OPTIONS = 512;

   // Phase encoding is also the low two bits of the status LEDs.
   typedef enum logic [1:0] {
      PH_RECEIVE  = 2'd0,
      PH_SOLVE    = 2'd1,
      PH_TRANSMIT = 2'd2,
      PH_ERROR    = 2'd3
   } phase_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_COUNT   = 2'd1,
      ERR_FIFO    = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_t;

endpackage

// File: rtl/sequencer_watchdog.sv
// Loadable up-counter used to bound the time spent solving one board.
// expired is raised while enabled and the count sits at the loaded limit.
module sequencer_watchdog #(
   parameter int WIDTH = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] limit,
   output logic             expired
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: clear wins, otherwise count up while enabled and stop at the limit.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = {WIDTH{1'b0}};
      end else if (enable && (count_q != limit)) begin
         count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= {WIDTH{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = enable && (count_q == limit);

endmodule

// File: rtl/nonogram_sequencer.sv
// Phase controller for the puzzle datapath: receive -> solve -> transmit.
// Owns the line FIFO write/read ports, pulses the solver and assembler
// starts, latches the board size and reports protocol faults on the LEDs.
module nonogram_sequencer
   import nonogram_pkg::*;
#(
   parameter int MAX_ROWS      = nonogram_pkg::MAX_ROWS,
   parameter int MAX_COLS      = nonogram_pkg::MAX_COLS,
   parameter int LINE_W        = nonogram_pkg::LINE_W,
   parameter int SOLVE_TIMEOUT = 50_000_000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        parsed,
   input  logic                        parse_write,
   input  logic [LINE_W-1:0]           parse_line,
   input  logic [$clog2(MAX_ROWS)-1:0] m_in,
   input  logic [$clog2(MAX_COLS)-1:0] n_in,
   input  logic                        solve_write,
   input  logic [LINE_W-1:0]           solve_line,
   input  logic                        solve_next,
   input  logic                        solved,
   input  logic                        assembled,
   input  logic                        fifo_full,
   input  logic                        fifo_empty,
   output logic                        fifo_wr_en,
   output logic [LINE_W-1:0]           fifo_din,
   output logic                        fifo_rd_en,
   output logic                        solve_start,
   output logic                        assemble_start,
   output logic [$clog2(MAX_ROWS)-1:0] m_out,
   output logic [$clog2(MAX_COLS)-1:0] n_out,
   output logic [1:0]                  phase,
   output logic [2:0]                  stat,
   output logic [1:0]                  err_code
);

   localparam int DIM_R = $clog2(MAX_ROWS);
   localparam int DIM_C = $clog2(MAX_COLS);
   localparam int CNT_W = $clog2(MAX_ROWS + MAX_COLS + 1);
   localparam int WD_W  = (SOLVE_TIMEOUT > 1) ? $clog2(SOLVE_TIMEOUT) : 1;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_ROWS + MAX_COLS);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(SOLVE_TIMEOUT - 1);

   phase_t           phase_q, phase_d;
   err_t             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DIM_R-1:0] m_q, m_d;
   logic [DIM_C-1:0] n_q, n_d;
   logic             solve_start_q, solve_start_d;
   logic             assemble_start_q, assemble_start_d;
   logic [2:0]       stat_q, stat_d;

   logic [CNT_W-1:0] cnt_incl;
   logic [CNT_W-1:0] target;
   logic [DIM_R-1:0] m_sel;
   logic [DIM_C-1:0] n_sel;
   logic             wd_run;
   logic             wd_expired;

   // Solve-time watchdog: held clear outside SOLVE so it restarts from 0 on entry.
   sequencer_watchdog #(
      .WIDTH (WD_W)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (~wd_run),
      .enable  (wd_run),
      .limit   (WD_LIMIT),
      .expired (wd_expired)
   );

   // Phase FSM next state, FIFO port muxing, line counting and fault detection.
   always_comb begin
      phase_d    = phase_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      m_sel      = m_q;
      n_sel      = n_q;
      fifo_wr_en = 1'b0;
      fifo_din   = {LINE_W{1'b0}};
      fifo_rd_en = 1'b0;
      wd_run     = 1'b0;
      cnt_incl   = cnt_q;
      target     = CNT_W'(m_in) + CNT_W'(n_in);
      case (phase_q)
         PH_RECEIVE: begin
            fifo_din   = parse_line;
            fifo_wr_en = parse_write & ~fifo_full;
            // A write in the same cycle as parsed counts toward the check.
            if (fifo_wr_en && (cnt_q != CNT_MAX)) begin
               cnt_incl = cnt_q + CNT_ONE;
            end else begin
               cnt_incl = cnt_q;
            end
            cnt_d = cnt_incl;
            if (parse_write && fifo_full) begin
               phase_d = PH_ERROR;
               err_d   = ERR_FIFO;
            end else if (parsed) begin
               if (cnt_incl == target) begin
                  phase_d = PH_SOLVE;
                  m_sel   = m_in;
                  n_sel   = n_in;
               end else begin
                  phase_d = PH_ERROR;
                  err_d   = ERR_COUNT;
               end
            end else begin
               phase_d = PH_RECEIVE;
            end
         end
         PH_SOLVE: begin
            wd_run     = 1'b1;
            fifo_din   = solve_line;
            fifo_wr_en = solve_write & ~fifo_full;
            fifo_rd_en = solve_next & ~fifo_empty;
            if ((solve_write && fifo_full) || (solve_next && fifo_empty)) begin
               phase_d = PH_ERROR;
               err_d   = ERR_FIFO;
            end else if (solved) begin
               // solved takes priority over a watchdog expiring in the same cycle
               phase_d = PH_TRANSMIT;
            end else if (wd_expired) begin
               phase_d = PH_ERROR;
               err_d   = ERR_TIMEOUT;
            end else begin
               phase_d = PH_SOLVE;
            end
         end
         PH_TRANSMIT: begin
            if (assembled) begin
               phase_d = PH_RECEIVE;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               phase_d = PH_TRANSMIT;
            end
         end
         PH_ERROR: begin
            phase_d = PH_ERROR;
         end
         default: begin
            phase_d = PH_ERROR;
            err_d   = ERR_FIFO;
         end
      endcase
   end

   // Registered outputs derived from the next phase; ERROR forces dimensions to 0.
   always_comb begin
      m_d              = (phase_d == PH_ERROR) ? {DIM_R{1'b0}} : m_sel;
      n_d              = (phase_d == PH_ERROR) ? {DIM_C{1'b0}} : n_sel;
      solve_start_d    = (phase_q == PH_RECEIVE) && (phase_d == PH_SOLVE);
      assemble_start_d = (phase_q == PH_SOLVE) && (phase_d == PH_TRANSMIT);
      stat_d           = {(err_d != ERR_NONE), phase_d};
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q          <= PH_RECEIVE;
         err_q            <= ERR_NONE;
         cnt_q            <= {CNT_W{1'b0}};
         m_q              <= {DIM_R{1'b0}};
         n_q              <= {DIM_C{1'b0}};
         solve_start_q    <= 1'b0;
         assemble_start_q <= 1'b0;
         stat_q           <= 3'b000;
      end else begin
         phase_q          <= phase_d;
         err_q            <= err_d;
         cnt_q            <= cnt_d;
         m_q              <= m_d;
         n_q              <= n_d;
         solve_start_q    <= solve_start_d;
         assemble_start_q <= assemble_start_d;
         stat_q           <= stat_d;
      end
   end

   assign solve_start    = solve_start_q;
   assign assemble_start = assemble_start_q;
   assign m_out          = m_q;
   assign n_out          = n_q;
   assign phase          = phase_q;
   assign stat           = stat_q;
   assign err_code       = err_q;

endmodule

// File: tb/tb_nonogram_sequencer.sv
// Self-checking bench for nonogram_sequencer: a small truth table for the
// FIFO port mux, directed multi-cycle scenarios, and randomized boards
// checked every cycle against a behavioural model.
module tb_nonogram_sequencer;

   localparam int LW = 16;
   localparam int MR = 11;
   localparam int MC = 11;
   localparam int TO = 100;

   logic        clk = 1'b0;
   logic        rst, parsed, parse_write, solve_write, solve_next, solved, assembled;
   logic        fifo_full, fifo_empty;
   logic [15:0] parse_line, solve_line;
   logic [3:0]  m_in, n_in;
   logic        fifo_wr_en, fifo_rd_en, solve_start, assemble_start;
   logic [15:0] fifo_din;
   logic [3:0]  m_out, n_out;
   logic [1:0]  phase, err_code;
   logic [2:0]  stat;

   always #5 clk = ~clk;

   nonogram_sequencer #(
      .MAX_ROWS(MR), .MAX_COLS(MC), .LINE_W(LW), .SOLVE_TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .parsed(parsed), .parse_write(parse_write),
      .parse_line(parse_line), .m_in(m_in), .n_in(n_in),
      .solve_write(solve_write), .solve_line(solve_line), .solve_next(solve_next),
      .solved(solved), .assembled(assembled), .fifo_full(fifo_full),
      .fifo_empty(fifo_empty), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
      .fifo_rd_en(fifo_rd_en), .solve_start(solve_start),
      .assemble_start(assemble_start), .m_out(m_out), .n_out(n_out),
      .phase(phase), .stat(stat), .err_code(err_code)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;
   int wr_seen  = 0;
   bit ss_seen  = 1'b0;

   // Behavioural model: phase 0..3, error code, accepted line count,
   // cycles already spent solving, latched dimensions and start pulses.
   int mp = 0, me = 0, mc = 0, mw = 0, mm = 0, mn = 0;
   bit mss = 1'b0, mas = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      bit          ewr, erd;
      logic [15:0] edin;
      ewr  = 1'b0;
      erd  = 1'b0;
      edin = 16'h0000;
      if (mp == 0) begin
         ewr  = parse_write && !fifo_full;
         edin = parse_line;
      end else if (mp == 1) begin
         ewr  = solve_write && !fifo_full;
         edin = solve_line;
         erd  = solve_next && !fifo_empty;
      end
      check("wr_mux", 32'({fifo_wr_en, fifo_din}), 32'({ewr, edin}));
      check("strobes", 32'({solve_start, assemble_start, fifo_rd_en}), 32'({mss, mas, erd}));
      check("dims", 32'({m_out, n_out}), 32'({4'(mm), 4'(mn)}));
      check("status", 32'({phase, stat, err_code}),
            32'({2'(mp), (me != 0), 2'(mp), 2'(me)}));
   endtask

   task automatic model_edge();
      int np, ne, nc, nw, nm, nn;
      bit nss, nas;
      np = mp; ne = me; nc = mc; nw = 0; nm = mm; nn = mn; nss = 1'b0; nas = 1'b0;
      if (rst) begin
         np = 0; ne = 0; nc = 0; nm = 0; nn = 0;
      end else begin
         if (mp == 0) begin
            if (parse_write && !fifo_full) nc = (mc + 1 > MR + MC) ? MR + MC : mc + 1;
            if (parse_write && fifo_full) begin
               np = 3; ne = 2;
            end else if (parsed) begin
               if (nc == (int'(m_in) + int'(n_in)) % 32) begin
                  np = 1; nm = int'(m_in); nn = int'(n_in); nss = 1'b1;
               end else begin
                  np = 3; ne = 1;
               end
            end
         end else if (mp == 1) begin
            if ((solve_write && fifo_full) || (solve_next && fifo_empty)) begin
               np = 3; ne = 2;
            end else if (solved) begin
               np = 2; nas = 1'b1;
            end else if (mw == TO - 1) begin
               np = 3; ne = 3;
            end else begin
               nw = mw + 1;
            end
         end else if (mp == 2) begin
            if (assembled) begin
               np = 0; nc = 0;
            end
         end
         if (np == 3) begin
            nm = 0; nn = 0;
         end
      end
      mp = np; me = ne; mc = nc; mw = nw; mm = nm; mn = nn; mss = nss; mas = nas;
   endtask

   // One clock: inputs already driven; compare before the edge, update model after.
   task automatic step();
      #1;
      if (chk_en) model_check();
      if (fifo_wr_en === 1'b1) wr_seen++;
      if (solve_start === 1'b1) ss_seen = 1'b1;
      @(posedge clk);
      model_edge();
      #1;
      rst = 1'b0; parsed = 1'b0; parse_write = 1'b0; solve_write = 1'b0;
      solve_next = 1'b0; solved = 1'b0; assembled = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
   endtask

   task automatic load_board(input int m, input int n, input int writes, input bit with_parsed);
      m_in = 4'(m);
      n_in = 4'(n);
      for (int i = 0; i < writes; i++) begin
         parse_write = 1'b1;
         parse_line  = 16'($urandom);
         if (with_parsed && i == writes - 1) parsed = 1'b1;
         step();
      end
      if (!with_parsed) begin
         parsed = 1'b1;
         step();
      end
   endtask

   typedef struct {
      bit          pw, ff, sw, sn, fe, sv;
      logic [15:0] pl, sl;
      bit          ewr;
      logic [15:0] edin;
      bit          erd;
   } vec_t;

   vec_t tbl[7];
   int   rm, rn, rw, rt, rk;

   initial begin
      rst = 1'b1; parsed = 1'b0; parse_write = 1'b0; solve_write = 1'b0;
      solve_next = 1'b0; solved = 1'b0; assembled = 1'b0; fifo_full = 1'b0;
      fifo_empty = 1'b0; parse_line = 16'h0000; solve_line = 16'h0000;
      m_in = 4'd0; n_in = 4'd0;

      // RECEIVE-phase port mux vectors: {pw,ff,sw,sn,fe,solved,pl,sl} -> {wr,din,rd}
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA5A5, 16'h0000, 1'b1, 16'hA5A5, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0, 16'h1234, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0F0F, 16'hFFFF, 1'b0, 16'h0F0F, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 16'hBEEF, 1'b0, 16'h0001, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7777, 16'h0000, 1'b0, 16'h7777, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h5555, 1'b1, 16'h8000, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hC3C3, 16'h0000, 1'b0, 16'hC3C3, 1'b0};

      step();
      chk_en = 1'b1;
      do_reset();
      check("reset_phase", 32'(phase), 32'd0);
      check("reset_outs", 32'({solve_start, assemble_start, m_out, n_out, stat, err_code}), 32'd0);

      // Table-driven mux checks in RECEIVE.
      for (int i = 0; i < 7; i++) begin
         parse_write = tbl[i].pw; fifo_full = tbl[i].ff; solve_write = tbl[i].sw;
         solve_next = tbl[i].sn; fifo_empty = tbl[i].fe; solved = tbl[i].sv;
         parse_line = tbl[i].pl; solve_line = tbl[i].sl;
         #1;
         check("tbl_wr", 32'({fifo_wr_en, fifo_din}), 32'({tbl[i].ewr, tbl[i].edin}));
         check("tbl_rd", 32'(fifo_rd_en), 32'(tbl[i].erd));
         step();
      end
      fifo_full = 1'b0; fifo_empty = 1'b0;
      check("tbl_no_err", 32'({phase, err_code}), 32'd0);
      do_reset();

      // 11x11 board, 22 writes then parsed.
      wr_seen = 0;
      load_board(11, 11, 22, 1'b0);
      check("b11_wr_count", 32'(wr_seen), 32'd22);
      check("b11_start", 32'({solve_start, m_out, n_out, phase, stat}),
            32'({1'b1, 4'd11, 4'd11, 2'd1, 3'b001}));
      step();
      check("b11_start_once", 32'(solve_start), 32'd0);
      parse_write = 1'b1;
      step();
      check("solve_stray_pw", 32'({phase, err_code}), 32'({2'd1, 2'd0}));
      fifo_full = 1'b1; solve_write = 1'b1;
      #1;
      check("ovf_suppress", 32'(fifo_wr_en), 32'd0);
      step();
      fifo_full = 1'b0;
      check("ovf_err", 32'({phase, err_code, stat, m_out}), 32'({2'd3, 2'd2, 3'b111, 4'd0}));
      parsed = 1'b1; solved = 1'b1;
      step();
      check("err_sticky", 32'({phase, err_code}), 32'({2'd3, 2'd2}));
      do_reset();

      // 21 writes for an 11x11 board: count mismatch.
      ss_seen = 1'b0;
      load_board(11, 11, 21, 1'b0);
      step();
      check("mismatch", 32'({phase, err_code, ss_seen}), 32'({2'd3, 2'd1, 1'b0}));
      do_reset();

      // Timeout with no solved; last write shares the cycle with parsed.
      load_board(3, 2, 5, 1'b1);
      check("same_cycle_wr", 32'(phase), 32'd1);
      for (int i = 0; i < TO - 1; i++) step();
      check("pre_timeout", 32'(phase), 32'd1);
      step();
      check("timeout", 32'({phase, err_code}), 32'({2'd3, 2'd3}));
      do_reset();

      // solved on the last allowed cycle wins over the timeout.
      load_board(2, 2, 4, 1'b0);
      for (int i = 0; i < TO - 1; i++) step();
      solved = 1'b1;
      step();
      check("solved_wins", 32'({phase, assemble_start, err_code}), 32'({2'd2, 1'b1, 2'd0}));
      parsed = 1'b1; solved = 1'b1;
      step();
      check("tx_stray", 32'({phase, assemble_start}), 32'({2'd2, 1'b0}));
      assembled = 1'b1;
      step();
      check("back_rx", 32'({phase, err_code}), 32'd0);
      load_board(5, 5, 10, 1'b0);
      check("second_board", 32'({phase, m_out, n_out, solve_start}),
            32'({2'd1, 4'd5, 4'd5, 1'b1}));

      // Underflow in SOLVE, then recover via reset.
      fifo_empty = 1'b1; solve_next = 1'b1;
      #1;
      check("udf_no_rd", 32'(fifo_rd_en), 32'd0);
      step();
      fifo_empty = 1'b0;
      check("underflow", 32'({phase, err_code}), 32'({2'd3, 2'd2}));
      do_reset();

      // Reset mid-SOLVE with solve_next high.
      load_board(1, 1, 2, 1'b0);
      solve_next = 1'b1; rst = 1'b1;
      step();
      solve_next = 1'b1;
      #1;
      check("rst_mid_solve", 32'({phase, fifo_rd_en, solve_start, assemble_start, m_out, n_out, stat, err_code}),
            32'd0);
      step();

      // Randomized boards checked cycle-by-cycle against the model.
      for (int b = 0; b < 40; b++) begin
         if (mp != 0) do_reset();
         rm = $urandom_range(1, 11);
         rn = $urandom_range(1, 11);
         rw = rm + rn;
         rt = $urandom_range(0, 9);
         if (rt == 0) rw = rw - 1;
         else if (rt == 1) rw = rw + 1;
         m_in = 4'(rm); n_in = 4'(rn);
         for (int i = 0; i < rw && mp == 0; i++) begin
            rk = $urandom_range(0, 2);
            for (int g = 0; g < rk; g++) begin
               solved = ($urandom_range(0, 4) == 0);
               assembled = ($urandom_range(0, 4) == 0);
               solve_write = ($urandom_range(0, 3) == 0);
               parse_line = 16'($urandom);
               step();
            end
            parse_write = 1'b1;
            parse_line = 16'($urandom);
            fifo_full = ($urandom_range(0, 60) == 0);
            step();
            fifo_full = 1'b0;
         end
         if (mp == 0) begin
            parsed = 1'b1;
            step();
         end
         if (mp == 1) begin
            rt = $urandom_range(0, 110);
            for (int c = 0; c < rt && mp == 1; c++) begin
               solve_next = ($urandom_range(0, 3) == 0);
               fifo_empty = ($urandom_range(0, 80) == 0);
               solve_write = ($urandom_range(0, 3) == 0);
               solve_line = 16'($urandom);
               fifo_full = ($urandom_range(0, 80) == 0);
               parse_write = ($urandom_range(0, 5) == 0);
               parsed = ($urandom_range(0, 20) == 0);
               assembled = ($urandom_range(0, 20) == 0);
               rst = ($urandom_range(0, 400) == 0);
               step();
               fifo_empty = 1'b0; fifo_full = 1'b0;
            end
            if (mp == 1) begin
               solved = 1'b1;
               step();
            end
         end
         if (mp == 2) begin
            rk = $urandom_range(0, 3);
            for (int g = 0; g < rk; g++) begin
               parsed = ($urandom_range(0, 1) == 0);
               solved = ($urandom_range(0, 1) == 0);
               step();
            end
            assembled = 1'b1;
            step();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
